voice_mixer: RTL and testbench



---
 rtl/voice_mixer_if.sv | 29 ++
 rtl/voice_mixer.sv | 165 ++++++++++++++++
 tb/tb_voice_mixer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// Voice bank to mixer link: the tick, voice samples and envelope controls in,
// the mixed sample and status flags out.
interface voice_mixer_if #(
  parameter int unsigned AUDIO_WIDTH = 32,
  parameter int unsigned NUM_VOICES  = 8,
  parameter int unsigned ENV_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH   = 24
);
  logic                                sample_tick;
  logic [NUM_VOICES*AUDIO_WIDTH-1:0]   voice_in;
  logic [NUM_VOICES-1:0]               ons_in;
  logic [ENV_WIDTH-1:0]                attack_step;
  logic [ENV_WIDTH-1:0]                release_step;
  logic [7:0]                          master_gain;
  logic signed [OUT_WIDTH-1:0]         mix_out;
  logic                                mix_valid;
  logic                                busy;
  logic                                tick_overrun;

  modport master (
    output sample_tick, voice_in, ons_in, attack_step, release_step, master_gain,
    input  mix_out, mix_valid, busy, tick_overrun
  );

  modport slave (
    input  sample_tick, voice_in, ons_in, attack_step, release_step, master_gain,
    output mix_out, mix_valid, busy, tick_overrun
  );
endinterface

// File: rtl/voice_mixer.sv
// Per-voice linear attack/release envelopes, time-multiplexed voice sum,
// master gain and output saturation; one mixed sample per sample_tick.
module voice_mixer #(
  parameter int unsigned AUDIO_WIDTH = 32,
  parameter int unsigned NUM_VOICES  = 8,
  parameter int unsigned ENV_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH   = 24
) (
  input  logic          clk,
  input  logic          rst,
  voice_mixer_if.slave  mix_if
);

  localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W  = AUDIO_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int unsigned PROD_W = AUDIO_WIDTH + ENV_WIDTH + 1;
  localparam int unsigned SCL_W  = ACC_W + 9;
  localparam int unsigned SHIFT  = 7 + AUDIO_WIDTH - OUT_WIDTH;
  localparam logic signed [SCL_W-1:0] SAT_MAX = SCL_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [SCL_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [NUM_VOICES*AUDIO_WIDTH-1:0] voice_q, voice_d;
  logic [NUM_VOICES-1:0]             ons_q, ons_d;
  logic [ENV_WIDTH-1:0]              atk_q, atk_d;
  logic [ENV_WIDTH-1:0]              rel_q, rel_d;
  logic [7:0]                        gain_q, gain_d;
  logic [ENV_WIDTH-1:0]              env_q [NUM_VOICES];
  logic [ENV_WIDTH-1:0]              env_d [NUM_VOICES];
  logic signed [ACC_W-1:0]           acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]       mix_out_q, mix_out_d;
  logic                              mix_valid_q, mix_valid_d;
  logic                              busy_q, busy_d;
  logic                              overrun_q, overrun_d;

  logic [ENV_WIDTH-1:0]              env_cur, env_new;
  logic [ENV_WIDTH:0]                env_sum, env_diff;
  logic signed [AUDIO_WIDTH-1:0]     voice_cur;
  logic signed [PROD_W-1:0]          prod_full;
  logic signed [ACC_W-1:0]           prod_ext;
  logic signed [SCL_W-1:0]           scl_full, scaled;

  // Envelope step for the current voice; one extra bit so both clamps see the carry/borrow
  always_comb begin
    env_cur   = env_q[idx_q];
    voice_cur = $signed(voice_q[idx_q*AUDIO_WIDTH +: AUDIO_WIDTH]);
    env_sum   = {1'b0, env_cur} + {1'b0, atk_q};
    env_diff  = {1'b0, env_cur} - {1'b0, rel_q};
    if (ons_q[idx_q]) begin
      env_new = env_sum[ENV_WIDTH] ? '1 : env_sum[ENV_WIDTH-1:0];
    end else begin
      env_new = env_diff[ENV_WIDTH] ? '0 : env_diff[ENV_WIDTH-1:0];
    end
    prod_full = PROD_W'(voice_cur) * PROD_W'($signed({1'b0, env_new}));
    prod_ext  = ACC_W'(prod_full >>> ENV_WIDTH);
    scl_full  = SCL_W'(acc_q) * SCL_W'($signed({1'b0, gain_q}));
    scaled    = scl_full >>> SHIFT;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    voice_d     = voice_q;
    ons_d       = ons_q;
    atk_d       = atk_q;
    rel_d       = rel_q;
    gain_d      = gain_q;
    env_d       = env_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (mix_if.sample_tick) begin
          voice_d = mix_if.voice_in;
          ons_d   = mix_if.ons_in;
          atk_d   = mix_if.attack_step;
          rel_d   = mix_if.release_step;
          gain_d  = mix_if.master_gain;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        env_d[idx_q] = env_new;
        acc_d        = acc_q + prod_ext;
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SCALE: begin
        // Saturated result lands in the output register as the OUT cycle begins
        if (scaled > SAT_MAX) begin
          mix_out_d = OUT_WIDTH'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
          mix_out_d = OUT_WIDTH'(SAT_MIN);
        end else begin
          mix_out_d = OUT_WIDTH'(scaled);
        end
        mix_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mix_if.sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      voice_q     <= '0;
      ons_q       <= '0;
      atk_q       <= '0;
      rel_q       <= '0;
      gain_q      <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        env_q[i] <= '0;
      end
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      voice_q     <= voice_d;
      ons_q       <= ons_d;
      atk_q       <= atk_d;
      rel_q       <= rel_d;
      gain_q      <= gain_d;
      env_q       <= env_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mix_if.mix_out      = mix_out_q;
  assign mix_if.mix_valid    = mix_valid_q;
  assign mix_if.busy         = busy_q;
  assign mix_if.tick_overrun = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: latency, envelope ramps, gain, saturation,
// overrun and reset abort, all against hand-computed values.
module tb_voice_mixer;
  localparam int unsigned AW = 32;
  localparam int unsigned NV = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  voice_mixer_if vif ();

  voice_mixer dut (
    .clk    (clk),
    .rst    (rst),
    .mix_if (vif)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic [AW-1:0] v);
    for (int k = 0; k < int'(NV); k++) vif.voice_in[k*AW +: AW] = v;
  endtask

  task automatic set_v0(input logic [AW-1:0] v);
    vif.voice_in = '0;
    vif.voice_in[AW-1:0] = v;
  endtask

  // One tick, then follow the mix to its pulse; optionally scramble inputs mid-mix
  task automatic run_mix(input string tag, input longint exp, input bit scramble);
    int lat;
    int busy_bad;
    vif.sample_tick = 1'b1;
    cycles(1);
    vif.sample_tick = 1'b0;
    if (scramble) begin
      set_all(32'h1234_5678);
      vif.ons_in      = '0;
      vif.master_gain = 8'd7;
    end
    lat      = 1;
    busy_bad = 0;
    while (!vif.mix_valid && lat < 30) begin
      if (!vif.busy) busy_bad++;
      cycles(1);
      lat++;
    end
    if (!vif.busy) busy_bad++;
    check({tag, " latency"}, lat, 10);
    check({tag, " busy"}, busy_bad, 0);
    check({tag, " mix_out"}, vif.mix_out, exp);
    cycles(1);
  endtask

  task automatic count_pulses(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 0; i < n; i++) begin
      if (vif.mix_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
      cycles(1);
    end
  endtask

  initial begin
    int pulses;
    int first;
    longint exp;

    rst              = 1'b1;
    vif.sample_tick  = 1'b1;
    vif.voice_in     = '0;
    vif.ons_in       = '0;
    vif.attack_step  = '0;
    vif.release_step = '0;
    vif.master_gain  = 8'd128;
    cycles(2);
    rst             = 1'b0;
    vif.sample_tick = 1'b0;
    check("reset mix_out", vif.mix_out, 0);
    check("reset mix_valid", longint'(vif.mix_valid), 0);
    check("reset busy", longint'(vif.busy), 0);
    check("reset overrun", longint'(vif.tick_overrun), 0);
    count_pulses(15, pulses, first);
    check("reset no pulse", pulses, 0);

    set_v0(32'd1000000);
    vif.ons_in      = 8'h01;
    vif.attack_step = 16'hFFFF;
    run_mix("single voice", 3906, 1'b0);
    check("idle busy", longint'(vif.busy), 0);

    rst = 1'b1;
    cycles(1);
    rst = 1'b0;

    // voice0 = 2^24 at unity gain makes mix_out equal to env0
    set_v0(32'h0100_0000);
    vif.attack_step = 16'h1000;
    for (int n = 1; n <= 17; n++) begin
      exp = (n * 4096 > 65535) ? 65535 : n * 4096;
      run_mix($sformatf("attack %0d", n), exp, 1'b0);
      cycles(9);
    end

    vif.ons_in       = 8'h00;
    vif.release_step = 16'h4000;
    run_mix("release 1", 49151, 1'b0);
    run_mix("release 2", 32767, 1'b0);
    run_mix("release 3", 16383, 1'b0);
    run_mix("release 4", 0, 1'b0);
    run_mix("release 5", 0, 1'b0);

    set_all(32'h7FFF_FFFF);
    vif.ons_in      = 8'hFF;
    vif.attack_step = 16'hFFFF;
    vif.master_gain = 8'd255;
    run_mix("sat pos", 8388607, 1'b0);
    set_all(32'h8000_0000);
    run_mix("sat neg", -8388608, 1'b0);
    vif.master_gain = 8'd0;
    run_mix("gain zero", 0, 1'b0);

    set_v0(-32'sd1000000);
    vif.ons_in      = 8'h01;
    vif.attack_step = 16'h0000;
    vif.master_gain = 8'd128;
    run_mix("neg floor 1", -3907, 1'b0);
    run_mix("neg floor 2", -3907, 1'b0);

    set_v0(32'h0100_0000);
    run_mix("snapshot", 65535, 1'b1);

    set_v0(32'h0100_0000);
    vif.ons_in      = 8'h01;
    vif.master_gain = 8'd128;
    vif.sample_tick = 1'b1;
    cycles(1);
    vif.sample_tick = 1'b0;
    cycles(2);
    vif.sample_tick = 1'b1;
    cycles(1);
    vif.sample_tick = 1'b0;
    count_pulses(26, pulses, first);
    check("overrun pulses", pulses, 1);
    check("overrun latency", first + 4, 10);
    check("overrun flag", longint'(vif.tick_overrun), 1);
    check("overrun mix_out", vif.mix_out, 65535);
    run_mix("after overrun", 65535, 1'b0);
    check("overrun held", longint'(vif.tick_overrun), 1);

    vif.sample_tick = 1'b1;
    cycles(1);
    vif.sample_tick = 1'b0;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("abort mix_out", vif.mix_out, 0);
    check("abort busy", longint'(vif.busy), 0);
    check("abort overrun", longint'(vif.tick_overrun), 0);
    count_pulses(20, pulses, first);
    check("abort no pulse", pulses, 0);

    vif.attack_step = 16'h1000;
    run_mix("env after abort", 4096, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
